// File: rtl/scroll_pkg.sv
// Shared encodings and default constants for the scroll sequencer.
//   state_e   : FSM state, which is also the externally visible mode code
//   chan_op_e : per-cycle command issued by the sequencer to every channel
package scroll_pkg;

  localparam int unsigned DEF_NCH      = 2;
  localparam int unsigned DEF_W        = 12;
  localparam int unsigned DEF_XMAX     = 640;
  localparam int unsigned DEF_SPLIT    = 128;
  localparam int unsigned DEF_JUMP_LEN = 4;
  localparam int unsigned DEF_DUCK_LEN = 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_JUMP = 2'd1,
    ST_DUCK = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CH_HOLD   = 3'd0,
    CH_INC    = 3'd1,
    CH_CLR    = 3'd2,
    CH_STORE  = 3'd3,
    CH_RESUME = 3'd4
  } chan_op_e;

endpackage

// File: rtl/scroll_chan.sv
// One position channel: wrapping counter, store register and resume adder.
//   clk_20, rst_n : clock, async active-low reset
//   op            : command from the sequencer (hold/inc/clear/store/resume)
//   add_len       : distance added to the stored value on resume
//   pos           : registered position, always in 0..XMAX-1
module scroll_chan
  import scroll_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned XMAX = DEF_XMAX
) (
  input  logic         clk_20,
  input  logic         rst_n,
  input  chan_op_e     op,
  input  logic [W-1:0] add_len,
  output logic [W-1:0] pos
);

  localparam int unsigned SW = W + 1;

  logic [W-1:0]  stored;
  logic [W-1:0]  pos_nxt;
  logic [W-1:0]  stored_nxt;
  logic [W-1:0]  pos_inc;
  logic [W-1:0]  pos_res;
  logic [SW-1:0] sum;

  // Wrap and resume arithmetic; the extra sum bit keeps stored+len exact before the modulo.
  always_comb begin
    sum     = SW'(stored) + SW'(add_len);
    pos_res = (sum >= SW'(XMAX)) ? W'(sum - SW'(XMAX)) : W'(sum);
    pos_inc = (pos == W'(XMAX - 1)) ? '0 : pos + W'(1);
  end

  // Command decode.
  always_comb begin
    pos_nxt    = pos;
    stored_nxt = stored;
    unique case (op)
      CH_INC:    pos_nxt    = pos_inc;
      CH_CLR:    pos_nxt    = '0;
      CH_STORE:  stored_nxt = pos;
      CH_RESUME: pos_nxt    = pos_res;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= '0;
      stored <= '0;
    end else begin
      pos    <= pos_nxt;
      stored <= stored_nxt;
    end
  end

endmodule

// File: rtl/scroll_seq.sv
// Scroll sequencer: RUN/JUMP/DUCK/DEAD FSM driving NCH lock-step position channels.
//   clk_20, rst_n     : clock, async active-low reset
//   tick              : advance enable for RUN, JUMP and DUCK
//   kp_jump, kp_down  : level-sampled action requests (jump wins)
//   dead              : game-over level, overrides everything
//   pos               : NCH packed positions, channel i at [i*W +: W]
//   mode              : current state code
//   lap               : half-lap phase flag
//   act_done          : one-cycle pulse when a jump or duck completes
module scroll_seq
  import scroll_pkg::*;
#(
  parameter int unsigned NCH      = DEF_NCH,
  parameter int unsigned W        = DEF_W,
  parameter int unsigned XMAX     = DEF_XMAX,
  parameter int unsigned SPLIT    = DEF_SPLIT,
  parameter int unsigned JUMP_LEN = DEF_JUMP_LEN,
  parameter int unsigned DUCK_LEN = DEF_DUCK_LEN
) (
  input  logic             clk_20,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             kp_jump,
  input  logic             kp_down,
  input  logic             dead,
  output logic [NCH*W-1:0] pos,
  output logic [1:0]       mode,
  output logic             lap,
  output logic             act_done
);

  localparam int unsigned TMAX = (JUMP_LEN > DUCK_LEN) ? JUMP_LEN : DUCK_LEN;
  localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  // When the split point is the last position, the ordinary wrap owns it.
  localparam bit SPLIT_IS_WRAP = (SPLIT == XMAX - 1);

  state_e        state, state_nxt;
  chan_op_e      chan_op;
  logic [W-1:0]  add_len;
  logic [TW-1:0] timer, timer_nxt;
  logic          lap_nxt;
  logic          act_nxt;
  logic          key;
  logic          at_split;
  logic          jump_last;
  logic          duck_last;

  assign key       = kp_jump | kp_down;
  assign at_split  = !SPLIT_IS_WRAP && (pos[W-1:0] == W'(SPLIT));
  assign jump_last = (timer == TW'(JUMP_LEN - 1));
  assign duck_last = (timer == TW'(DUCK_LEN - 1));

  // State register.
  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (dead) begin
      state_nxt = ST_DEAD;
    end else begin
      unique case (state)
        ST_RUN:  if (tick && kp_jump)      state_nxt = ST_JUMP;
                 else if (tick && kp_down) state_nxt = ST_DUCK;
        ST_JUMP: if (tick && jump_last)    state_nxt = ST_RUN;
        ST_DUCK: if (tick && duck_last)    state_nxt = ST_RUN;
        ST_DEAD:                           state_nxt = ST_RUN;
        default:                           state_nxt = ST_RUN;
      endcase
    end
  end

  // Datapath commands and next values of timer, lap and act_done.
  always_comb begin
    chan_op   = CH_HOLD;
    add_len   = W'(JUMP_LEN);
    timer_nxt = timer;
    lap_nxt   = lap;
    act_nxt   = 1'b0;
    if (!dead) begin
      unique case (state)
        ST_RUN: begin
          if (tick) begin
            if (key) begin
              chan_op   = CH_STORE;
              timer_nxt = '0;
            end else if (at_split && !lap) begin
              chan_op = CH_CLR;
              lap_nxt = 1'b1;
            end else begin
              chan_op = CH_INC;
              if (at_split) lap_nxt = 1'b0;
            end
          end
        end
        ST_JUMP: begin
          if (tick) begin
            if (jump_last) begin
              chan_op   = CH_RESUME;
              timer_nxt = '0;
              act_nxt   = 1'b1;
            end else begin
              timer_nxt = timer + TW'(1);
            end
          end
        end
        ST_DUCK: begin
          add_len = W'(DUCK_LEN);
          if (tick) begin
            if (duck_last) begin
              chan_op   = CH_RESUME;
              timer_nxt = '0;
              act_nxt   = 1'b1;
            end else begin
              timer_nxt = timer + TW'(1);
            end
          end
        end
        ST_DEAD: begin
          chan_op   = CH_CLR;
          lap_nxt   = 1'b0;
          timer_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      lap      <= 1'b0;
      act_done <= 1'b0;
    end else begin
      timer    <= timer_nxt;
      lap      <= lap_nxt;
      act_done <= act_nxt;
    end
  end

  assign mode = 2'(state);

  // All channels receive the same command, so they only differ by their own wrap.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    scroll_chan #(
      .W    (W),
      .XMAX (XMAX)
    ) u_chan (
      .clk_20  (clk_20),
      .rst_n   (rst_n),
      .op      (chan_op),
      .add_len (add_len),
      .pos     (pos[i*W +: W])
    );
  end

endmodule

// File: tb/tb_scroll_seq.sv
// Directed bench for scroll_seq: vector tables for actions, loops for long idle runs.
module tb_scroll_seq;
  import scroll_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned W   = 12;

  logic             clk_20 = 1'b0;
  logic             rst_n;
  logic             tick;
  logic             kp_jump;
  logic             kp_down;
  logic             dead;
  logic [NCH*W-1:0] pos;
  logic [1:0]       mode;
  logic             lap;
  logic             act_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        tick;
    logic        jmp;
    logic        dwn;
    logic        dead;
    int unsigned pos;
    logic [1:0]  mode;
    logic        lap;
    logic        act;
  } vec_t;

  vec_t vq[$];

  scroll_seq #(
    .NCH(NCH), .W(W), .XMAX(640), .SPLIT(128), .JUMP_LEN(4), .DUCK_LEN(4)
  ) dut (
    .clk_20   (clk_20),
    .rst_n    (rst_n),
    .tick     (tick),
    .kp_jump  (kp_jump),
    .kp_down  (kp_down),
    .dead     (dead),
    .pos      (pos),
    .mode     (mode),
    .lap      (lap),
    .act_done (act_done)
  );

  always #25 clk_20 = ~clk_20;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NCH*W-1:0] rep(int unsigned p);
    logic [NCH*W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = W'(p);
    return r;
  endfunction

  task automatic chk(string nm, int unsigned p, logic [1:0] m, logic l, logic a);
    n_cmp++;
    if (pos !== rep(p)) begin
      n_bad++;
      $display("FAIL %s pos: got %h want %h", nm, pos, rep(p));
    end
    n_cmp++;
    if (mode !== m) begin
      n_bad++;
      $display("FAIL %s mode: got %0d want %0d", nm, mode, m);
    end
    n_cmp++;
    if (lap !== l) begin
      n_bad++;
      $display("FAIL %s lap: got %0b want %0b", nm, lap, l);
    end
    n_cmp++;
    if (act_done !== a) begin
      n_bad++;
      $display("FAIL %s act_done: got %0b want %0b", nm, act_done, a);
    end
  endtask

  task automatic step(logic t, logic j, logic d, logic dd);
    tick = t; kp_jump = j; kp_down = d; dead = dd;
    @(posedge clk_20);
    #1;
  endtask

  // Plain ticks with no keys, over a stretch that never meets the split point.
  task automatic idle(int n, int unsigned start, logic l);
    for (int k = 1; k <= n; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("idle_from_%0d+%0d", start, k), start + k, 2'd0, l, 1'b0);
    end
  endtask

  task automatic add(logic t, logic j, logic d, logic dd,
                     int unsigned p, logic [1:0] m, logic l, logic a);
    vec_t v;
    v.tick = t; v.jmp = j; v.dwn = d; v.dead = dd;
    v.pos = p; v.mode = m; v.lap = l; v.act = a;
    vq.push_back(v);
  endtask

  task automatic run_vq(string tag);
    foreach (vq[k]) begin
      step(vq[k].tick, vq[k].jmp, vq[k].dwn, vq[k].dead);
      chk($sformatf("%s[%0d]", tag, k), vq[k].pos, vq[k].mode, vq[k].lap, vq[k].act);
    end
    vq.delete();
  endtask

  initial begin
    rst_n = 1'b1; tick = 1'b0; kp_jump = 1'b0; kp_down = 1'b0; dead = 1'b0;
    #5 rst_n = 1'b0;
    @(posedge clk_20);
    @(posedge clk_20);
    #1;
    chk("reset", 0, 2'd0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;

    // Tick gating, then the half-lap restart at channel 0 = 128.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_tick_hold", 0, 2'd0, 1'b0, 1'b0);
    idle(128, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("half_lap_restart", 0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_restart", 1, 2'd0, 1'b1, 1'b0);

    // Jump over the split while lap=1, keys and tick gaps ignored mid-jump.
    idle(125, 1, 1'b1);
    add(1, 1, 0, 0, 126, 2'd1, 1, 0);
    add(1, 0, 1, 0, 126, 2'd1, 1, 0);
    add(0, 1, 1, 0, 126, 2'd1, 1, 0);
    add(1, 0, 0, 0, 126, 2'd1, 1, 0);
    add(1, 1, 0, 0, 126, 2'd1, 1, 0);
    add(1, 0, 0, 0, 130, 2'd0, 1, 1);
    add(0, 0, 0, 0, 130, 2'd0, 1, 0);
    run_vq("jump_over_split");

    // Lap wrap at 639 with lap=1.
    idle(509, 130, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_639", 0, 2'd0, 1'b1, 1'b0);

    // Jump from 100.
    idle(100, 0, 1'b1);
    add(1, 1, 0, 0, 100, 2'd1, 1, 0);
    add(0, 0, 0, 0, 100, 2'd1, 1, 0);
    add(1, 0, 1, 0, 100, 2'd1, 1, 0);
    add(1, 0, 0, 0, 100, 2'd1, 1, 0);
    add(1, 0, 0, 0, 100, 2'd1, 1, 0);
    add(1, 0, 0, 0, 104, 2'd0, 1, 1);
    add(0, 0, 0, 0, 104, 2'd0, 1, 0);
    run_vq("jump_100");

    // Second pass through the split with lap=1 clears lap and keeps counting.
    idle(24, 104, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("split_lap1", 129, 2'd0, 1'b0, 1'b0);

    // Duck from 638 resumes modulo the lap length.
    idle(509, 129, 1'b0);
    add(1, 0, 1, 0, 638, 2'd2, 0, 0);
    add(1, 1, 0, 0, 638, 2'd2, 0, 0);
    add(1, 0, 0, 0, 638, 2'd2, 0, 0);
    add(1, 0, 0, 0, 638, 2'd2, 0, 0);
    add(1, 0, 0, 0,   2, 2'd0, 0, 1);
    add(1, 0, 0, 0,   3, 2'd0, 0, 0);
    run_vq("duck_638");

    // Both keys (jump wins), then dead mid-jump, then recovery.
    idle(47, 3, 1'b0);
    add(1, 1, 1, 0, 50, 2'd1, 0, 0);
    add(1, 0, 0, 0, 50, 2'd1, 0, 0);
    add(0, 0, 0, 1, 50, 2'd3, 0, 0);
    add(1, 1, 0, 1, 50, 2'd3, 0, 0);
    add(0, 0, 0, 0,  0, 2'd0, 0, 0);
    add(1, 0, 0, 0,  1, 2'd0, 0, 0);
    run_vq("dead_mid_jump");

    // Reset while ducking with timer=2.
    add(1, 0, 1, 0, 1, 2'd2, 0, 0);
    add(1, 0, 0, 0, 1, 2'd2, 0, 0);
    add(1, 0, 0, 0, 1, 2'd2, 0, 0);
    run_vq("duck_pre_reset");
    tick = 1'b1;
    #10 rst_n = 1'b0;
    #1;
    chk("reset_mid_duck", 0, 2'd0, 1'b0, 1'b0);
    @(posedge clk_20);
    #1;
    chk("reset_held", 0, 2'd0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("post_reset_%0d", k), k, 2'd0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
